// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state encoding and memory-request payload for the
// 8-line x 4-byte direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned TAG_W      = 3;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned OFF_W      = 2;
  localparam int unsigned LINES      = 8;
  localparam int unsigned BLOCK_W    = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned ADDR_W     = TAG_W + IDX_W + OFF_W;
  localparam int unsigned BLK_ADDR_W = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    FILL      = 2'd3
  } state_e;

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [BLK_ADDR_W-1:0] addr;
    logic [BLOCK_W-1:0]    wdata;
  } mem_req_t;

endpackage

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM: decides write-back/fetch/fill sequencing and drives the
// memory-side request; the line arrays live in the parent.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               hit,
  input  logic               victim_dirty,
  input  logic               mem_busywait,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic [IDX_W-1:0]   idx,
  input  logic [TAG_W-1:0]   victim_tag,
  input  logic [BLOCK_W-1:0] victim_data,
  output state_e             state_q,
  output mem_req_t           mem_req_c,
  output logic               busy_c
);

  state_e state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_req_c = '0;
    busy_c    = 1'b0;
    case (state_q)
      IDLE: begin
        busy_c = req & ~hit;
        if (req && !hit) state_d = victim_dirty ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        busy_c          = 1'b1;
        mem_req_c.wr    = 1'b1;
        mem_req_c.addr  = {victim_tag, idx};
        mem_req_c.wdata = victim_data;
        if (!mem_busywait) state_d = FETCH;
      end
      FETCH: begin
        busy_c         = 1'b1;
        mem_req_c.rd   = 1'b1;
        mem_req_c.addr = {req_tag, idx};
        if (!mem_busywait) state_d = FILL;
      end
      FILL: begin
        busy_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 bytes.
// Hits complete without stalling; misses are sequenced by dcache_ctrl.
module dcache
  import dcache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [BYTE_W-1:0]     WRITEDATA,
  output logic [BYTE_W-1:0]     READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [BLK_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;

  logic [LINES-1:0]              valid_q, valid_d;
  logic [LINES-1:0]              dirty_q, dirty_d;
  logic [LINES-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [LINES-1:0][BLOCK_W-1:0] data_q, data_d;

  logic     hit_c;
  logic     busy_c;
  state_e   state_q;
  mem_req_t mem_req_c;

  assign tag   = ADDRESS[ADDR_W-1 -: TAG_W];
  assign idx   = ADDRESS[OFF_W +: IDX_W];
  assign off   = ADDRESS[OFF_W-1:0];
  assign hit_c = valid_q[idx] & (tag_q[idx] == tag);

  dcache_ctrl u_ctrl (
    .clk          (CLK),
    .rst_n        (RESET),
    .req          (READ | WRITE),
    .hit          (hit_c),
    .victim_dirty (valid_q[idx] & dirty_q[idx]),
    .mem_busywait (MEM_BUSYWAIT),
    .req_tag      (tag),
    .idx          (idx),
    .victim_tag   (tag_q[idx]),
    .victim_data  (data_q[idx]),
    .state_q      (state_q),
    .mem_req_c    (mem_req_c),
    .busy_c       (busy_c)
  );

  // Reset must silence the stall even while a request is still held high.
  assign BUSYWAIT      = RESET & busy_c;
  assign MEM_READ      = mem_req_c.rd;
  assign MEM_WRITE     = mem_req_c.wr;
  assign MEM_ADDRESS   = mem_req_c.addr;
  assign MEM_WRITEDATA = mem_req_c.wdata;
  assign READDATA      = (READ && hit_c && state_q == IDLE)
                         ? data_q[idx][{off, 3'b000} +: BYTE_W] : '0;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (state_q == FILL) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      tag_d[idx]   = tag;
      data_d[idx]  = MEM_READDATA;
    end else if (state_q == IDLE && WRITE && hit_c) begin
      data_d[idx][{off, 3'b000} +: BYTE_W] = WRITEDATA;
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tags and data are only meaningful under a valid bit, so they skip reset.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: a transaction-level cache/memory model predicts
// the per-cycle CPU and memory-side outputs, checked on every falling edge.
module tb_dcache;

  localparam int MEM_LAT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  dcache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Data memory device: each request holds MEM_BUSYWAIT high for MEM_LAT-1 cycles.
  logic [31:0] dev_mem [64];
  logic [31:0] rdata_q;
  int          mem_cnt;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < MEM_LAT - 1);
  assign MEM_READDATA = rdata_q;

  always @(posedge CLK) begin
    if (!(MEM_READ | MEM_WRITE)) mem_cnt <= 0;
    else if (MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
    else begin
      mem_cnt <= 0;
      if (MEM_WRITE) dev_mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      if (MEM_READ)  rdata_q <= dev_mem[MEM_ADDRESS];
    end
  end

  // Reference model state.
  bit [7:0]    m_valid, m_dirty;
  logic [2:0]  m_tag  [8];
  logic [31:0] m_data [8];
  logic [31:0] ref_mem[64];

  typedef struct {
    logic        busy, mrd, mwr;
    logic [5:0]  maddr;
    logic [31:0] mwd;
    logic [7:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  task automatic push(input logic busy, input logic mrd, input logic mwr,
                      input logic [5:0] maddr, input logic [31:0] mwd, input logic [7:0] rd);
    exp_t e;
    e.busy = busy; e.mrd = mrd; e.mwr = mwr; e.maddr = maddr; e.mwd = mwd; e.rd = rd;
    exp_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check("busywait",  32'(BUSYWAIT),  32'(cur.busy));
      check("mem_read",  32'(MEM_READ),  32'(cur.mrd));
      check("mem_write", 32'(MEM_WRITE), 32'(cur.mwr));
      if (cur.mrd || cur.mwr) check("mem_address", 32'(MEM_ADDRESS), 32'(cur.maddr));
      if (cur.mwr) check("mem_writedata", MEM_WRITEDATA, cur.mwd);
      check("readdata", 32'(READDATA), 32'(cur.rd));
    end
  end

  // One CPU access: predict the whole cycle sequence, then hold the request.
  task automatic do_access(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                           input int lit_rd, input int lit_lat);
    logic [2:0] idx, tg;
    logic [1:0] off;
    logic [5:0] vaddr;
    logic [7:0] byte_v;
    int n;
    idx = a[4:2]; tg = a[7:5]; off = a[1:0];
    n = 0;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      push(1, 0, 0, 6'h0, 32'h0, 8'h00); n++;
      if (m_valid[idx] && m_dirty[idx]) begin
        vaddr = {m_tag[idx], idx};
        for (int i = 0; i < MEM_LAT; i++) begin push(1, 0, 1, vaddr, m_data[idx], 8'h00); n++; end
        ref_mem[vaddr] = m_data[idx];
      end
      for (int i = 0; i < MEM_LAT; i++) begin push(1, 1, 0, a[7:2], 32'h0, 8'h00); n++; end
      push(1, 0, 0, 6'h0, 32'h0, 8'h00); n++;
      m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0;
      m_tag[idx] = tg; m_data[idx] = ref_mem[a[7:2]];
    end
    byte_v = m_data[idx][int'(off)*8 +: 8];
    if (lit_rd >= 0 && !wr) begin
      check("model_readdata", 32'(byte_v), 32'(lit_rd));
      byte_v = 8'(lit_rd);
    end
    if (lit_lat >= 0) check("model_latency", 32'(n), 32'(lit_lat));
    push(0, 0, 0, 6'h0, 32'h0, wr ? 8'h00 : byte_v);
    n++;
    if (wr) begin
      m_data[idx][int'(off)*8 +: 8] = wd;
      m_dirty[idx] = 1'b1;
    end
    READ = ~wr; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    repeat (n) @(posedge CLK);
    #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(0, 0, 0, 6'h0, 32'h0, 8'h00);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busywait"},  32'(BUSYWAIT),  32'h0);
    check({tag, "_mem_read"},  32'(MEM_READ),  32'h0);
    check({tag, "_mem_write"}, 32'(MEM_WRITE), 32'h0);
    check({tag, "_mem_addr"},  32'(MEM_ADDRESS), 32'h0);
    check({tag, "_mem_wdata"}, MEM_WRITEDATA, 32'h0);
    check({tag, "_readdata"},  32'(READDATA), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A00_A500;
      dev_mem[i] <= (32'(i) * 32'h0101_0101) ^ 32'h5A00_A500;
    end
    ref_mem[5] = 32'hDDCC_BBAA;     dev_mem[5] <= 32'hDDCC_BBAA;
    ref_mem[6'h2D] = 32'h4433_2211; dev_mem[6'h2D] <= 32'h4433_2211;
    rdata_q <= 32'h0;
    mem_cnt <= 0;
    m_valid = '0; m_dirty = '0;
    for (int i = 0; i < 8; i++) begin m_tag[i] = 3'h0; m_data[i] = 32'h0; end

    // Reset with a request already pending: everything must stay quiet.
    RESET = 1'b0; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h14; WRITEDATA = 8'h00;
    #12;
    check_reset_outputs("reset");
    READ = 1'b0;
    #10 RESET = 1'b1;
    @(posedge CLK); #1;

    idle(2);
    do_access(1'b0, 8'h14, 8'h00, 8'hAA, 6);
    do_access(1'b0, 8'h17, 8'h00, 8'hDD, 0);
    do_access(1'b1, 8'h15, 8'h5A, -1, 0);
    do_access(1'b0, 8'h15, 8'h00, 8'h5A, 0);
    idle(1);
    check("model_victim_data", m_data[5], 32'hDDCC_5AAA);
    check("model_victim_dirty", 32'(m_dirty[5]), 32'h1);
    do_access(1'b0, 8'hB4, 8'h00, 8'h11, 10);
    idle(1);
    do_access(1'b1, 8'h2B, 8'h77, -1, 6);
    do_access(1'b0, 8'h2B, 8'h00, 8'h77, 0);
    do_access(1'b0, 8'h28, 8'h00, -1, 0);

    // Reset in the middle of a fetch drops the request asynchronously.
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h14;
    push(1, 0, 0, 6'h0, 32'h0, 8'h00);
    push(1, 1, 0, 6'h05, 32'h0, 8'h00);
    repeat (2) @(posedge CLK);
    #2;
    check("pre_reset_mem_read", 32'(MEM_READ), 32'h1);
    check("pre_reset_busywait", 32'(BUSYWAIT), 32'h1);
    RESET = 1'b0;
    #1;
    check_reset_outputs("midfetch");
    READ = 1'b0;
    @(negedge CLK); #2;
    RESET = 1'b1;
    m_valid = '0; m_dirty = '0;
    @(posedge CLK); #1;
    do_access(1'b0, 8'h14, 8'h00, 8'hAA, 6);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
